h_secded_decoder_pipe: RTL

Parametrised, pipelined extended-Hamming SECDED decoder with valid/ready flow control on both sides. It accepts full-length codewords of N = 2^R bits: the overall parity sits at position 0, the Hamming parity bits at power-of-two positions, and data occupies every other position. It corrects single errors, flags double errors, and keeps saturating error counters. It sits on the receive side of protected links and memories, between the codeword source and the data consumer.

---
 rtl/h_secded_decoder_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/h_secded_decoder_pipe.sv
// h_secded_decoder_pipe: two-stage extended-Hamming SECDED decoder with valid/ready
// flow control on both sides and saturating corrected/detected error counters.
`default_nettype none

module h_secded_decoder_pipe #(
    parameter int R     = 6,
    parameter int CNT_W = 16,
    localparam int N    = 1 << R,
    localparam int K    = N - R - 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [N-1:0]     i_CodeWord,
    input  logic             i_CorrEn,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [K-1:0]     o_DecodWord,
    output logic [R-1:0]     o_Syndrome,
    output logic             o_ErrorC,
    output logic             o_ErrorD,
    input  logic             i_CntClr,
    output logic [CNT_W-1:0] o_CntC,
    output logic [CNT_W-1:0] o_CntD
);

    // Codeword position of data bit k: k-th non-power-of-two position >= 3.
    function automatic int data_pos(input int k);
        int cnt;
        data_pos = 0;
        cnt      = 0;
        for (int p = 3; p < N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == k) data_pos = p;
                cnt++;
            end
        end
    endfunction

    logic           ld1, ld2, in_hs, out_hs;
    logic [R-1:0]   syn0;
    logic           pm0;

    logic           v1, en1, pm1;
    logic [N-1:0]   cw1;
    logic [R-1:0]   syn1;

    logic [N-1:0]   fixed;
    logic [K-1:0]   data_x;
    logic           syn_nz, err_c_nx, err_d_nx;

    logic           v2, err_c, err_d;
    logic [K-1:0]   data2;
    logic [R-1:0]   syn2;
    logic [CNT_W-1:0] cnt_c, cnt_d;

    assign ld2    = ~v2 | i_Ready;
    assign ld1    = ~v1 | ld2;
    assign in_hs  = i_Valid & ld1;
    assign out_hs = v2 & i_Ready;

    always_comb begin
        syn0 = '0;
        for (int p = 1; p < N; p++) begin
            for (int j = 0; j < R; j++) begin
                if (p[j]) syn0[j] = syn0[j] ^ i_CodeWord[p];
            end
        end
    end

    assign pm0 = ^i_CodeWord;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            v1   <= 1'b0;
            en1  <= 1'b0;
            pm1  <= 1'b0;
            cw1  <= '0;
            syn1 <= '0;
        end else if (ld1) begin
            v1 <= in_hs;
            if (in_hs) begin
                cw1  <= i_CodeWord;
                en1  <= i_CorrEn;
                syn1 <= syn0;
                pm1  <= pm0;
            end
        end
    end

    // Syndrome 0 with pm set points at the overall parity bit, which carries no data.
    always_comb begin
        fixed = cw1;
        if (en1 && pm1) fixed[syn1] = ~cw1[syn1];
    end

    for (genvar k = 0; k < K; k++) begin : g_extract
        localparam int P = data_pos(k);
        assign data_x[k] = fixed[P];
    end

    assign syn_nz   = |syn1;
    assign err_c_nx = en1 & pm1;
    assign err_d_nx = en1 ? (~pm1 & syn_nz) : (pm1 | syn_nz);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            v2    <= 1'b0;
            data2 <= '0;
            syn2  <= '0;
            err_c <= 1'b0;
            err_d <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                data2 <= data_x;
                syn2  <= syn1;
                err_c <= err_c_nx;
                err_d <= err_d_nx;
            end
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_c <= '0;
            cnt_d <= '0;
        end else if (i_CntClr) begin
            cnt_c <= '0;
            cnt_d <= '0;
        end else if (out_hs) begin
            if (err_c && !(&cnt_c)) cnt_c <= cnt_c + 1'b1;
            if (err_d && !(&cnt_d)) cnt_d <= cnt_d + 1'b1;
        end
    end

    assign o_Ready     = ld1;
    assign o_Valid     = v2;
    assign o_DecodWord = data2;
    assign o_Syndrome  = syn2;
    assign o_ErrorC    = err_c;
    assign o_ErrorD    = err_d;
    assign o_CntC      = cnt_c;
    assign o_CntD      = cnt_d;

endmodule

`default_nettype wire
